// File: rtl/mod_counter_n_pkg.sv
// rtl/mod_counter_n_pkg.sv - shared encodings and helpers for the modulo-N counter family
package mod_counter_n_pkg;

    // Values of the sat input
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Values of the up input
    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    // Bits needed to hold 0..value-1; returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mod_counter_n_tick.sv
// rtl/mod_counter_n_tick.sv - enable-qualified prescaler producing one tick every PRESCALE enabled cycles
module tick_divider
    import mod_counter_n_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic resetp,
    input  logic enable,
    input  logic restart,
    output logic tick
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            // Every enabled cycle is a tick; no prescaler state exists
            logic unused_inputs;
            assign unused_inputs = clock | resetp | restart;
            assign tick          = enable;
        end else begin : g_count
            localparam int            PW   = clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] p;

            // Prescaler phase: zeroed by reset or restart, otherwise advances on enable and wraps
            always_ff @(posedge clock) begin
                if (resetp) begin
                    p <= '0;
                end else if (restart) begin
                    p <= '0;
                end else if (enable) begin
                    p <= (p == LAST) ? '0 : p + PW'(1);
                end
            end

            assign tick = enable & (p == LAST);
        end
    endgenerate

endmodule

// File: rtl/mod_counter_n.sv
// rtl/mod_counter_n.sv - parametrised up/down modulo-N counter with prescaler, load, saturate and sticky overflow
module mod_counter_n
    import mod_counter_n_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             resetp,
    input  logic             enable,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    generate
        if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH) || PRESCALE < 1) begin : g_bad_params
            $error("mod_counter_n: illegal WIDTH/MODULUS/PRESCALE combination");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic             tick;
    logic             step;
    logic             at_limit;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] load_clamped;

    // A load restarts the prescaler so the next step comes a full period after it
    tick_divider #(
        .PRESCALE(PRESCALE)
    ) u_tick (
        .clock  (clock),
        .resetp (resetp),
        .enable (enable),
        .restart(load),
        .tick   (tick)
    );

    assign limit        = (up == DIR_DOWN) ? '0 : MAX;
    assign at_limit     = (q == limit);
    assign step         = tick & ~load;
    assign tc           = step & at_limit;
    assign load_clamped = (load_value > MAX) ? MAX : load_value;

    // Count register: reset, then load, then a step toward or past the directional limit
    always_ff @(posedge clock) begin
        if (resetp) begin
            q <= '0;
        end else if (load) begin
            q <= load_clamped;
        end else if (step) begin
            if (at_limit) begin
                if (sat == MODE_WRAP) begin
                    q <= (up == DIR_UP) ? '0 : MAX;
                end
            end else if (up == DIR_UP) begin
                q <= q + WIDTH'(1);
            end else begin
                q <= q - WIDTH'(1);
            end
        end
    end

    // Sticky overflow: a limit step sets it and beats a simultaneous clear
    always_ff @(posedge clock) begin
        if (resetp) begin
            ovf <= 1'b0;
        end else if (tc) begin
            ovf <= 1'b1;
        end else if (clear_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_counter_n.sv
// tb/tb_mod_counter_n.sv - self-checking bench for mod_counter_n against an integer reference model
module tb_mod_counter_n;

    logic       clock;
    logic       resetp;
    logic       en;
    logic       up;
    logic       sat;
    logic       ld;
    logic [3:0] lv;
    logic       clr;

    logic [3:0] q_a, q_b, q_c;
    logic       tc_a, tc_b, tc_c;
    logic       ovf_a, ovf_b, ovf_c;

    logic       cas_en;
    logic       cas_up;
    logic       cas_sat;
    logic       cas_ld;
    logic [3:0] cas_lv;
    logic       cas_clr;
    logic [3:0] q_u, q_t;
    logic       tc_u, tc_t, ovf_u, ovf_t;

    int checks;
    int failures;

    typedef struct {
        int q;
        int p;
        bit ovf;
    } mstate_t;

    mstate_t sa, sb, sc;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    mod_counter_n #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) dut_a (
        .clock(clock), .resetp(resetp), .enable(en), .up(up), .sat(sat), .load(ld),
        .load_value(lv), .clear_ovf(clr), .q(q_a), .tc(tc_a), .ovf(ovf_a));

    mod_counter_n #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_b (
        .clock(clock), .resetp(resetp), .enable(en), .up(up), .sat(sat), .load(ld),
        .load_value(lv), .clear_ovf(clr), .q(q_b), .tc(tc_b), .ovf(ovf_b));

    mod_counter_n #(.WIDTH(4), .MODULUS(12), .PRESCALE(4)) dut_c (
        .clock(clock), .resetp(resetp), .enable(en), .up(up), .sat(sat), .load(ld),
        .load_value(lv), .clear_ovf(clr), .q(q_c), .tc(tc_c), .ovf(ovf_c));

    mod_counter_n #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_units (
        .clock(clock), .resetp(resetp), .enable(cas_en), .up(cas_up), .sat(cas_sat), .load(cas_ld),
        .load_value(cas_lv), .clear_ovf(cas_clr), .q(q_u), .tc(tc_u), .ovf(ovf_u));

    mod_counter_n #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) dut_tens (
        .clock(clock), .resetp(resetp), .enable(tc_u), .up(cas_up), .sat(cas_sat), .load(cas_ld),
        .load_value(cas_lv), .clear_ovf(cas_clr), .q(q_t), .tc(tc_t), .ovf(ovf_t));

    // Terminal count predicted from the current inputs and model state
    function automatic bit m_tc(mstate_t s, int m, int ps);
        int lim;
        lim = up ? m - 1 : 0;
        return en && !ld && (s.p == ps - 1) && (s.q == lim);
    endfunction

    // Next model state after one clock edge with the current inputs
    function automatic mstate_t m_next(mstate_t s, int m, int ps);
        mstate_t n;
        bit      tk;
        bit      hit;
        int      lim;
        n   = s;
        lim = up ? m - 1 : 0;
        tk  = en && (s.p == ps - 1);
        hit = tk && (s.q == lim);
        if (resetp) begin
            n.q = 0; n.p = 0; n.ovf = 0;
        end else if (ld) begin
            n.q = (int'(lv) > m - 1) ? m - 1 : int'(lv);
            n.p = 0;
            if (clr) n.ovf = 0;
        end else begin
            if (en) n.p = (s.p + 1) % ps;
            if (tk) begin
                if (hit) n.q = sat ? s.q : (up ? 0 : m - 1);
                else     n.q = up ? s.q + 1 : s.q - 1;
            end
            if (hit)      n.ovf = 1;
            else if (clr) n.ovf = 0;
        end
        return n;
    endfunction

    // Advance models, then one full clock; returns just after the following negedge
    task automatic tick_clk();
        sa = m_next(sa, 16, 1);
        sb = m_next(sb, 10, 1);
        sc = m_next(sc, 12, 4);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        resetp = 1'b1; en = 1'b1; ld = 1'b1; lv = 4'($urandom_range(0, 15)); clr = 1'b0;
        #1;
        tick_clk();
        checks++;
        if (q_a !== 4'd0 || q_b !== 4'd0 || q_c !== 4'd0 || q_u !== 4'd0 || q_t !== 4'd0) begin
            failures++;
            $display("FAIL reset_q got a=%0d b=%0d c=%0d u=%0d t=%0d exp all 0", q_a, q_b, q_c, q_u, q_t);
        end
        checks++;
        if (ovf_a !== 1'b0 || ovf_b !== 1'b0 || ovf_c !== 1'b0 || ovf_u !== 1'b0 || ovf_t !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf got a=%0b b=%0b c=%0b u=%0b t=%0b exp all 0", ovf_a, ovf_b, ovf_c, ovf_u, ovf_t);
        end
        resetp = 1'b0; ld = 1'b0; en = 1'b0;
    endtask

    task automatic test_wrap_default();
        resetp = 1'b0; ld = 1'b0; clr = 1'b0; up = 1'b1; sat = 1'b0; en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            #1;
            checks++;
            if (q_a !== 4'(i % 16)) begin
                failures++;
                $display("FAIL wrap_q i=%0d got=%0d exp=%0d", i, q_a, i % 16);
            end
            checks++;
            if (tc_a !== ((i % 16) == 15)) begin
                failures++;
                $display("FAIL wrap_tc i=%0d got=%0b exp=%0b", i, tc_a, (i % 16) == 15);
            end
            checks++;
            if (ovf_a !== (i >= 16)) begin
                failures++;
                $display("FAIL wrap_ovf i=%0d got=%0b exp=%0b", i, ovf_a, i >= 16);
            end
            if (i < 17) tick_clk();
        end
        en = 1'b0;
    endtask

    task automatic test_sat_down();
        int exp_q [5] = '{2, 1, 0, 0, 0};
        up = 1'b0; sat = 1'b1; en = 1'b0; ld = 1'b1; lv = 4'd2; clr = 1'b1;
        #1;
        tick_clk();
        ld = 1'b0; en = 1'b1; clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            clr = (i >= 3);
            #1;
            checks++;
            if (q_b !== 4'(exp_q[i])) begin
                failures++;
                $display("FAIL satdn_q i=%0d got=%0d exp=%0d", i, q_b, exp_q[i]);
            end
            checks++;
            if (tc_b !== (i >= 2)) begin
                failures++;
                $display("FAIL satdn_tc i=%0d got=%0b exp=%0b", i, tc_b, i >= 2);
            end
            checks++;
            if (ovf_b !== (i >= 3)) begin
                failures++;
                $display("FAIL satdn_ovf i=%0d got=%0b exp=%0b", i, ovf_b, i >= 3);
            end
            tick_clk();
        end
        checks++;
        if (ovf_b !== 1'b1) begin
            failures++;
            $display("FAIL satdn_set_wins got=%0b exp=1", ovf_b);
        end
        en = 1'b0; clr = 1'b1;
        #1;
        tick_clk();
        checks++;
        if (ovf_b !== 1'b0) begin
            failures++;
            $display("FAIL satdn_clear got=%0b exp=0", ovf_b);
        end
        clr = 1'b0;
    endtask

    task automatic test_clamp();
        up = 1'b1; sat = 1'b0; clr = 1'b0; ld = 1'b1; lv = 4'd13; en = 1'b1;
        #1;
        checks++;
        if (tc_b !== 1'b0) begin
            failures++;
            $display("FAIL clamp_tc_during_load got=%0b exp=0", tc_b);
        end
        tick_clk();
        checks++;
        if (q_b !== 4'd9) begin
            failures++;
            $display("FAIL clamp_q got=%0d exp=9", q_b);
        end
        ld = 1'b0;
        #1;
        checks++;
        if (tc_b !== 1'b1) begin
            failures++;
            $display("FAIL clamp_tc_at_max got=%0b exp=1", tc_b);
        end
        tick_clk();
        checks++;
        if (q_b !== 4'd0 || ovf_b !== 1'b1) begin
            failures++;
            $display("FAIL clamp_wrap got q=%0d ovf=%0b exp q=0 ovf=1", q_b, ovf_b);
        end
        en = 1'b0;
    endtask

    task automatic test_prescale();
        resetp = 1'b1; ld = 1'b0; clr = 1'b0; en = 1'b0;
        #1;
        tick_clk();
        resetp = 1'b0; up = 1'b1; sat = 1'b0; en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++;
            if (q_c !== 4'(k / 4)) begin
                failures++;
                $display("FAIL presc_q k=%0d got=%0d exp=%0d", k, q_c, k / 4);
            end
            tick_clk();
        end
        ld = 1'b1; lv = 4'd5;
        #1;
        tick_clk();
        ld = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #1;
            checks++;
            if (q_c !== ((j < 4) ? 4'd5 : 4'd6)) begin
                failures++;
                $display("FAIL presc_after_load j=%0d got=%0d exp=%0d", j, q_c, (j < 4) ? 5 : 6);
            end
            if (j < 4) tick_clk();
        end
        en = 1'b0;
    endtask

    task automatic test_cascade();
        en = 1'b0; ld = 1'b0; clr = 1'b0; cas_en = 1'b1;
        for (int i = 0; i < 102; i++) begin
            #1;
            checks++;
            if (q_u !== 4'(i % 10) || q_t !== 4'((i / 10) % 10)) begin
                failures++;
                $display("FAIL cascade_q i=%0d got=%0d%0d exp=%0d%0d", i, q_t, q_u, (i / 10) % 10, i % 10);
            end
            checks++;
            if (tc_t !== ((i % 100) == 99) || tc_u !== ((i % 10) == 9)) begin
                failures++;
                $display("FAIL cascade_tc i=%0d got t=%0b u=%0b", i, tc_t, tc_u);
            end
            tick_clk();
        end
        cas_en = 1'b0;
    endtask

    task automatic test_reset_priority();
        up = 1'b1; sat = 1'b0; clr = 1'b0; en = 1'b0; ld = 1'b1; lv = 4'd11;
        #1;
        tick_clk();
        ld = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin #1; tick_clk(); end
        ld = 1'b1; lv = 4'd7;
        #1;
        tick_clk();
        ld = 1'b0;
        for (int i = 0; i < 2; i++) begin #1; tick_clk(); end
        checks++;
        if (q_c !== 4'd7 || ovf_c !== 1'b1) begin
            failures++;
            $display("FAIL rstpri_setup got q=%0d ovf=%0b exp q=7 ovf=1", q_c, ovf_c);
        end
        resetp = 1'b1; ld = 1'b1; lv = 4'd3; en = 1'b1;
        #1;
        tick_clk();
        checks++;
        if (q_c !== 4'd0 || ovf_c !== 1'b0) begin
            failures++;
            $display("FAIL rstpri_reset got q=%0d ovf=%0b exp q=0 ovf=0", q_c, ovf_c);
        end
        resetp = 1'b0; ld = 1'b0; en = 1'b1;
        for (int i = 0; i < 2; i++) begin #1; tick_clk(); end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (q_c !== 4'd0 || tc_c !== 1'b0) begin
                failures++;
                $display("FAIL rstpri_hold i=%0d got q=%0d tc=%0b exp q=0 tc=0", i, q_c, tc_c);
            end
            tick_clk();
        end
        en = 1'b1;
        #1;
        tick_clk();
        checks++;
        if (q_c !== 4'd0) begin
            failures++;
            $display("FAIL rstpri_p3 got=%0d exp=0", q_c);
        end
        #1;
        tick_clk();
        checks++;
        if (q_c !== 4'd1) begin
            failures++;
            $display("FAIL rstpri_step got=%0d exp=1", q_c);
        end
        en = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            resetp = ($urandom_range(0, 79) == 0);
            en     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) up = ~up;
            sat    = 1'($urandom_range(0, 1));
            ld     = ($urandom_range(0, 11) == 0);
            lv     = 4'($urandom_range(0, 15));
            clr    = ($urandom_range(0, 7) == 0);
            #1;
            checks++;
            if (tc_a !== m_tc(sa, 16, 1) || tc_b !== m_tc(sb, 10, 1) || tc_c !== m_tc(sc, 12, 4)) begin
                failures++;
                $display("FAIL rand_tc i=%0d got a=%0b b=%0b c=%0b exp a=%0b b=%0b c=%0b", i,
                         tc_a, tc_b, tc_c, m_tc(sa, 16, 1), m_tc(sb, 10, 1), m_tc(sc, 12, 4));
            end
            tick_clk();
            checks++;
            if (q_a !== 4'(sa.q) || q_b !== 4'(sb.q) || q_c !== 4'(sc.q)) begin
                failures++;
                $display("FAIL rand_q i=%0d got a=%0d b=%0d c=%0d exp a=%0d b=%0d c=%0d", i,
                         q_a, q_b, q_c, sa.q, sb.q, sc.q);
            end
            checks++;
            if (ovf_a !== sa.ovf || ovf_b !== sb.ovf || ovf_c !== sc.ovf) begin
                failures++;
                $display("FAIL rand_ovf i=%0d got a=%0b b=%0b c=%0b exp a=%0b b=%0b c=%0b", i,
                         ovf_a, ovf_b, ovf_c, sa.ovf, sb.ovf, sc.ovf);
            end
            checks++;
            if (q_b > 4'd9 || q_c > 4'd11) begin
                failures++;
                $display("FAIL rand_range i=%0d got b=%0d c=%0d", i, q_b, q_c);
            end
        end
        resetp = 1'b0; en = 1'b0; ld = 1'b0; clr = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sa = '{0, 0, 1'b0};
        sb = '{0, 0, 1'b0};
        sc = '{0, 0, 1'b0};
        resetp = 1'b1; en = 1'b0; up = 1'b1; sat = 1'b0; ld = 1'b0; lv = 4'd0; clr = 1'b0;
        cas_en = 1'b0; cas_up = 1'b1; cas_sat = 1'b0; cas_ld = 1'b0; cas_lv = 4'd0; cas_clr = 1'b0;
        @(negedge clock);
        test_reset();
        test_wrap_default();
        test_sat_down();
        test_clamp();
        test_prescale();
        test_cascade();
        test_reset_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
